ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard.

---
 rtl/ps2_host_tx.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one byte to the device using the request-to-send sequence: inhibit
// the clock, issue the start bit, shift 8 data bits LSB-first, then odd
// parity and stop. The bits change on filtered falling edges of the
// device-generated PS2Clk. After the stop bit the device ACK is sampled.
// The pins are open-drain and shared with the receive path. An *_oe output
// of 1 pulls the line low.
//
// Ports:
//   clk, rst_n     system clock; asynchronous active-low reset
//   tx_data        command byte, captured when tx_valid && tx_ready
//   tx_valid       transfer request
//   tx_ready       idle and able to accept a byte
//   tx_busy        transfer in progress; the receive path ignores the lines
//   tx_done        1-cycle pulse: byte sent and ACK received
//   tx_err         1-cycle pulse: no ACK, or the transfer timed out
//   ps2_clk_in     PS2Clk pin level (asynchronous)
//   ps2_data_in    PS2Data pin level (asynchronous)
//   ps2_clk_oe     1 = pull PS2Clk low
//   ps2_data_oe    1 = pull PS2Data low

// Pin conditioner: 2-flop synchroniser, then a level that only follows the
// synchronised pin after FILTER_LEN consecutive samples disagree with it.
module ps2_host_tx_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level
);
    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], pin};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [20:0] TO_LAST = 21'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state;
    logic [IW-1:0] inh_cnt;
    logic [20:0]   to_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    data_q;
    logic          parity_q;
    logic          clk_f;
    logic          data_f;
    logic          clk_f_d;
    logic          fall;

    ps2_host_tx_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ps2_clk_in),
        .level (clk_f)
    );

    ps2_host_tx_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (ps2_data_in),
        .level (data_f)
    );

    assign fall = clk_f_d & ~clk_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            bit_idx     <= '0;
            data_q      <= '0;
            parity_q    <= 1'b0;
            clk_f_d     <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            clk_f_d <= clk_f;

            case (state)
                S_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    // Ready comes back one cycle after the done/err pulse.
                    if (!tx_ready) begin
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                    end else if (tx_valid) begin
                        data_q      <= tx_data;
                        parity_q    <= ~^tx_data;
                        tx_ready    <= 1'b0;
                        tx_busy     <= 1'b1;
                        inh_cnt     <= '0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= (INHIBIT_CYCLES == 1);
                        state       <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;
                        to_cnt      <= '0;
                        bit_idx     <= '0;
                        state       <= S_START;
                    end else begin
                        inh_cnt <= inh_cnt + IW'(1);
                        // Start bit is already low during the last inhibit cycle.
                        if (inh_cnt == IW'(INHIBIT_CYCLES - 2)) begin
                            ps2_data_oe <= 1'b1;
                        end
                    end
                end

                default: begin
                    // START/SHIFT/ACK/WAIT_IDLE share one timeout that runs from START entry.
                    if (to_cnt == TO_LAST) begin
                        tx_err      <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 21'd1;
                        case (state)
                            S_START: begin
                                state <= S_SHIFT;
                            end
                            S_SHIFT: begin
                                if (fall) begin
                                    if (bit_idx < 4'd8) begin
                                        ps2_data_oe <= ~data_q[bit_idx[2:0]];
                                    end else if (bit_idx == 4'd8) begin
                                        ps2_data_oe <= ~parity_q;
                                    end else begin
                                        ps2_data_oe <= 1'b0;
                                        state       <= S_ACK;
                                    end
                                    bit_idx <= bit_idx + 4'd1;
                                end
                            end
                            S_ACK: begin
                                if (fall) begin
                                    if (!data_f) begin
                                        state <= S_WAIT_IDLE;
                                    end else begin
                                        tx_err <= 1'b1;
                                        state  <= S_IDLE;
                                    end
                                end
                            end
                            S_WAIT_IDLE: begin
                                if (clk_f && data_f) begin
                                    tx_done <= 1'b1;
                                    state   <= S_IDLE;
                                end
                            end
                            default: begin
                                state <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx. It uses a behavioural PS/2 device that clocks
// with a 40-cycle half period, samples PS2Data on its rising clock edges,
// and can be told to ACK or not. It can also inject a clock glitch or stop
// mid-frame. Frames are compared against a parity/stop model computed from
// the byte.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TO  = 2000;
    localparam int FL  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Event monitor, sampled 1 time unit after the falling edge.
    int   cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
    int   t_start = -1, t_err = -1, t_done = -1, t_acc = -1;
    int   run_len = 0, last_run = 0;
    logic prev_clk_oe = 1'b0;
    logic [1:0] oe_at_err = 2'b00;

    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (prev_clk_oe && !ps2_clk_oe) t_start = cyc;
        if (ps2_clk_oe) run_len++;
        else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (tx_done) begin done_cnt++; t_done = cyc; end
        if (tx_err) begin err_cnt++; t_err = cyc; oe_at_err = {ps2_clk_oe, ps2_data_oe}; end
        if (tx_done && tx_err) both_cnt++;
        if (tx_valid && tx_ready) begin acc_cnt++; t_acc = cyc; end
        prev_clk_oe = ps2_clk_oe;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required earlier end", $time);
        $fatal(1);
    end

    // Expected frame as the device sees it: {stop, parity, data[7:0]}.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones = 0;
        logic [9:0] f;
        for (int i = 0; i < 8; i++) begin
            f[i] = b[i];
            ones += int'(b[i]);
        end
        f[8] = ((ones % 2) == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        while (!tx_ready && w < 5000) begin @(negedge clk); w++; end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Device model: waits for the start condition, then produces 11 clock pulses.
    task automatic device_run(input bit give_ack, input int glitch_edge, input int abort_edge,
                              output logic [9:0] got, output bit started);
        int w = 0;
        got = '0;
        started = 1'b0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) return;
        started = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            if (e == glitch_edge) begin
                repeat (20) @(negedge clk);
                dev_clk_low = 1'b1;
                @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (19) @(negedge clk);
            end else if (e == 11) begin
                repeat (20) @(negedge clk);
                dev_data_low = give_ack;
                repeat (20) @(negedge clk);
            end else begin
                repeat (40) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            if (e == abort_edge) return;
            repeat (20) @(negedge clk);
            if (e <= 10) got[e-1] = ps2_data_line;
            dev_clk_low = 1'b0;
        end
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic do_transfer(input logic [7:0] b, input int glitch_edge, input bit give_ack,
                               output logic [9:0] got, output bit started,
                               output int d_done, output int d_err);
        int d0 = done_cnt;
        int e0 = err_cnt;
        int w = 0;
        send_byte(b);
        device_run(give_ack, glitch_edge, 0, got, started);
        while (done_cnt == d0 && err_cnt == e0 && w < 100) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        d_done = done_cnt - d0;
        d_err  = err_cnt - e0;
    endtask

    task automatic test_reset();
        int d0, e0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe} !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_outputs got %b required 100000",
                     {tx_ready, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        // Device clock activity while idle must be ignored.
        d0 = done_cnt; e0 = err_cnt;
        for (int k = 0; k < 3; k++) begin
            dev_clk_low = 1'b1; repeat (10) @(negedge clk);
            dev_clk_low = 1'b0; repeat (10) @(negedge clk);
        end
        n_cmp++;
        if ({done_cnt - d0, err_cnt - e0} !== {32'd0, 32'd0} || tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_edges got done=%0d err=%0d ready=%b required 0 0 1",
                     done_cnt - d0, err_cnt - e0, tx_ready);
        end
    endtask

    task automatic test_send_ed();
        logic [9:0] got;
        bit st;
        int dd, de;
        do_transfer(8'hED, 0, 1'b1, got, st, dd, de);
        n_cmp++;
        if (last_run !== INH) begin
            n_bad++;
            $display("FAIL ed_inhibit_len got %0d required %0d", last_run, INH);
        end
        n_cmp++;
        if (got !== model_frame(8'hED) || !st) begin
            n_bad++;
            $display("FAIL ed_frame got %b required %b", got, model_frame(8'hED));
        end
        n_cmp++;
        if (dd !== 1 || de !== 0 || tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ed_done got done=%0d err=%0d ready=%b required 1 0 1", dd, de, tx_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] got;
        bit st;
        int d0, a0, w;
        d0 = done_cnt;
        send_byte(8'hF4);
        device_run(1'b1, 0, 0, got, st);
        n_cmp++;
        if (got !== model_frame(8'hF4)) begin
            n_bad++;
            $display("FAIL f4_frame got %b required %b", got, model_frame(8'hF4));
        end
        a0 = acc_cnt;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        w = 0;
        while (acc_cnt == a0 && w < 200) begin @(negedge clk); w++; end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        n_cmp++;
        if (done_cnt - d0 !== 1 || t_acc !== t_done + 1) begin
            n_bad++;
            $display("FAIL b2b_accept got done=%0d accept_cycle=%0d required 1 and %0d",
                     done_cnt - d0, t_acc, t_done + 1);
        end
        device_run(1'b1, 0, 0, got, st);
        w = 0;
        while (done_cnt - d0 < 2 && w < 100) begin @(negedge clk); w++; end
        n_cmp++;
        if (got !== model_frame(8'hFF)) begin
            n_bad++;
            $display("FAIL ff_frame got %b required %b", got, model_frame(8'hFF));
        end
        n_cmp++;
        if (done_cnt - d0 !== 2) begin
            n_bad++;
            $display("FAIL ff_done got %0d required 2", done_cnt - d0);
        end
    endtask

    task automatic test_no_ack();
        logic [9:0] got;
        bit st;
        int dd, de;
        do_transfer(8'h00, 0, 1'b0, got, st, dd, de);
        n_cmp++;
        if (got !== model_frame(8'h00)) begin
            n_bad++;
            $display("FAIL noack_frame got %b required %b", got, model_frame(8'h00));
        end
        n_cmp++;
        if (dd !== 0 || de !== 1 || oe_at_err !== 2'b00 || {ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            n_bad++;
            $display("FAIL noack_err got done=%0d err=%0d oe_at_err=%b required 0 1 00", dd, de, oe_at_err);
        end
    endtask

    task automatic test_timeout();
        int e0, w;
        e0 = err_cnt;
        send_byte(8'($urandom));
        w = 0;
        while (err_cnt == e0 && w < 2600) begin @(negedge clk); w++; end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (err_cnt - e0 !== 1 || t_err - t_start !== TO) begin
            n_bad++;
            $display("FAIL timeout_delay got err=%0d delay=%0d required 1 and %0d",
                     err_cnt - e0, t_err - t_start, TO);
        end
        n_cmp++;
        if (oe_at_err !== 2'b00 || tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_release got oe=%b ready=%b required 00 1", oe_at_err, tx_ready);
        end
    endtask

    task automatic test_glitch();
        logic [9:0] got;
        logic [7:0] b;
        bit st;
        int dd, de;
        b = 8'($urandom);
        do_transfer(b, 5, 1'b1, got, st, dd, de);
        n_cmp++;
        if (got !== model_frame(b) || dd !== 1 || de !== 0) begin
            n_bad++;
            $display("FAIL glitch_frame got %b done=%0d err=%0d required %b 1 0",
                     got, dd, de, model_frame(b));
        end
    endtask

    task automatic test_random();
        logic [9:0] got;
        logic [7:0] b;
        bit st;
        int dd, de;
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            do_transfer(b, 0, 1'b1, got, st, dd, de);
            n_cmp++;
            if (got !== model_frame(b) || dd !== 1 || de !== 0) begin
                n_bad++;
                $display("FAIL random_frame byte=%h got %b done=%0d err=%0d required %b 1 0",
                         b, got, dd, de, model_frame(b));
            end
        end
    endtask

    task automatic test_abort();
        logic [9:0] got;
        bit st;
        int d0, e0, dd, de;
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hED);
        device_run(1'b1, 0, 5, got, st);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            n_bad++;
            $display("FAIL abort_release got %b required 00", {ps2_clk_oe, ps2_data_oe});
        end
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (tx_ready !== 1'b1 || done_cnt != d0 || err_cnt != e0) begin
            n_bad++;
            $display("FAIL abort_state got ready=%b done=%0d err=%0d required 1 0 0",
                     tx_ready, done_cnt - d0, err_cnt - e0);
        end
        do_transfer(8'hED, 0, 1'b1, got, st, dd, de);
        n_cmp++;
        if (got !== model_frame(8'hED) || dd !== 1 || de !== 0) begin
            n_bad++;
            $display("FAIL abort_resend got %b done=%0d err=%0d required %b 1 0",
                     got, dd, de, model_frame(8'hED));
        end
        n_cmp++;
        if (both_cnt !== 0) begin
            n_bad++;
            $display("FAIL done_err_overlap got %0d required 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_back_to_back();
        test_no_ack();
        test_timeout();
        test_glitch();
        test_random();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
